alu_share_arbiter: RTL
======================

// Module: alu_share_arbiter
// PURPOSE
//  Shares one combinational alu instance between two requesters, e.g. the main
//  datapath (Req0) and a branch/address helper (Req1).
//  Issue uses a round-robin valid/ready handshake.
//  Each accepted op passes through a 2-stage pipeline: issue register, then result register.
//  Results come back on a shared response bus with per-requester valid strobes.
//  Throughput is one op per cycle; an illegal-function flag is returned with each result.
// PARAMETERS
//  DATA_W  32  operand/result width (must match alu A_in/B_in/O_out)
//  FUNC_W  6   ALU function code width (must match alu Func_in)
// PORTS
//  Clk_in           in   1       clock; all state changes on rising edge
//  Reset_n_in       in   1       asynchronous, active-low reset
//  Req0_valid_in    in   1       requester 0 presents an op
//  Req0_func_in     in   FUNC_W  requester 0 ALU function code
//  Req0_a_in        in   DATA_W  requester 0 operand A (shamt in [4:0] for shifts)
//  Req0_b_in        in   DATA_W  requester 0 operand B
//  Req0_ready_out   out  1       requester 0 op accepted this cycle
//  Req1_*           -    -       identical set for requester 1
//  Resp0_valid_out  out  1       response bus carries requester 0 result (1-cycle pulse)
//  Resp1_valid_out  out  1       response bus carries requester 1 result (1-cycle pulse)
//  Resp_result_out  out  DATA_W  registered ALU O_out
//  Resp_branch_out  out  1       registered ALU Branch_out
//  Resp_jump_out    out  1       registered ALU Jump_out
//  Resp_err_out     out  1       func code was illegal; result forced to 0
//  Alu_func_out     out  FUNC_W  to alu Func_in
//  Alu_a_out        out  DATA_W  to alu A_in
//  Alu_b_out        out  DATA_W  to alu B_in
//  Alu_o_in         in   DATA_W  from alu O_out
//  Alu_branch_in    in   1       from alu Branch_out
//  Alu_jump_in      in   1       from alu Jump_out
//  Busy_out         out  1       issue or result stage holds a valid op
// BEHAVIOUR
//  Reset: all outputs 0; issue/result stages invalid; round-robin pointer = Req0.
//   Reset takes effect asynchronously, including mid-operation.
//   In-flight ops are discarded and no response is ever produced for them.
//  Arbitration (combinational, every cycle; no stall, since the response is never backpressured):
//   - Exactly one of Req0_ready_out/Req1_ready_out may be high, and only if that requester's valid is high.
//   - Only one requester valid: it is granted.
//   - Both valid: the requester named by the pointer is granted.
//   - Pointer: after any grant, pointer = the other requester. With no grant, pointer holds.
//   - Ready may depend on the other requester's valid; a requester must hold its inputs until ready.
//  Stage 1 (issue): at the grant edge, capture {owner, func, a, b}; set valid.
//   - Alu_*_out come directly from these registers.
//   - When stage 1 is invalid, Alu_func_out/Alu_a_out/Alu_b_out = 0.
//  Stage 2 (result): at the next edge, capture Alu_o_in, Alu_branch_in and Alu_jump_in, plus owner and err.
//   - Exactly one of Resp0_valid_out/Resp1_valid_out pulses for one cycle.
//  Latency: accepted at edge T; response valid during the cycle after edge T+1.
//   Back-to-back grants produce back-to-back responses in grant order.
//  Legal func codes (checked on stage-1 func):
//   - 1000xx, 1001xx, 101xxx, 111xxx, 000000, 000010, 000011.
//   - Any other code: Resp_err_out=1 and Resp_result_out/branch/jump = 0.
//     The ALU output is ignored in that case.
//  Resp_err/result/branch/jump are only meaningful while a Resp valid is high.
//   Between responses they hold the last captured value.
//  Busy_out = stage1 valid OR stage2 valid.
// TESTING
//  1. Reset, then Req0 ADD (100000) with A=5, B=7 at edge T
//     -> Resp0_valid=1 after T+1; result=12; Resp1_valid=0.
//  2. Both valid every cycle; Req0 SUB 10-3, Req1 SLTU (101001) 1<2
//     -> grants alternate 0,1,0,1; responses 7, 1, 7, 1 in grant order.
//  3. Req1 BEQ (111100) with A=B=0x55 -> Resp1_valid, branch=1, jump=0, result=0x55.
//     Same op with B=0x56 -> branch=0.
//  4. Req0 func 010101 (illegal) -> Resp0_valid=1, err=1, result=0.
//     A following legal SLL (000000) with A=4, B=1 -> err=0, result=0x10.
//  5. Assert Reset_n_in low with both stages valid
//     -> Busy, all Resp valids and Alu_* drop immediately.
//     After release: no stale response; first grant goes to Req0.
//  6. Req1 only for 3 cycles, then both valid
//     -> 4th grant goes to Req0 (pointer flipped by last Req1 grant).

Source files
------------

// File: rtl/alu_share_arbiter.sv
// rtl/alu_share_arbiter.sv - round-robin front end sharing one combinational ALU between two requesters
module alu_share_arbiter #(
  parameter int DATA_W = 32,
  parameter int FUNC_W = 6
) (
  input  logic              Clk_in,
  input  logic              Reset_n_in,
  input  logic              Req0_valid_in,
  input  logic [FUNC_W-1:0] Req0_func_in,
  input  logic [DATA_W-1:0] Req0_a_in,
  input  logic [DATA_W-1:0] Req0_b_in,
  output logic              Req0_ready_out,
  input  logic              Req1_valid_in,
  input  logic [FUNC_W-1:0] Req1_func_in,
  input  logic [DATA_W-1:0] Req1_a_in,
  input  logic [DATA_W-1:0] Req1_b_in,
  output logic              Req1_ready_out,
  output logic              Resp0_valid_out,
  output logic              Resp1_valid_out,
  output logic [DATA_W-1:0] Resp_result_out,
  output logic              Resp_branch_out,
  output logic              Resp_jump_out,
  output logic              Resp_err_out,
  output logic [FUNC_W-1:0] Alu_func_out,
  output logic [DATA_W-1:0] Alu_a_out,
  output logic [DATA_W-1:0] Alu_b_out,
  input  logic [DATA_W-1:0] Alu_o_in,
  input  logic              Alu_branch_in,
  input  logic              Alu_jump_in,
  output logic              Busy_out
);

  logic              rr_ptr;
  logic              grant0;
  logic              grant1;
  logic              grant_any;
  logic              s1_valid;
  logic              s1_owner;
  logic [FUNC_W-1:0] s1_func;
  logic [DATA_W-1:0] s1_a;
  logic [DATA_W-1:0] s1_b;
  logic              s1_legal;
  logic              s2_valid;
  logic              s2_owner;

  // rr_ptr names the requester that wins when both are valid; ready is held low during reset
  assign grant0    = Reset_n_in & Req0_valid_in & (~Req1_valid_in | ~rr_ptr);
  assign grant1    = Reset_n_in & Req1_valid_in & (~Req0_valid_in | rr_ptr);
  assign grant_any = grant0 | grant1;

  assign Req0_ready_out = grant0;
  assign Req1_ready_out = grant1;

  always_comb begin
    s1_legal = 1'b0;
    casez (s1_func)
      6'b100???, 6'b101???, 6'b111???,
      6'b000000, 6'b000010, 6'b000011: s1_legal = 1'b1;
      default:                         s1_legal = 1'b0;
    endcase
  end

  // issue stage clears its payload when idle so the ALU inputs read zero
  always_ff @(posedge Clk_in or negedge Reset_n_in) begin
    if (!Reset_n_in) begin
      rr_ptr   <= 1'b0;
      s1_valid <= 1'b0;
      s1_owner <= 1'b0;
      s1_func  <= '0;
      s1_a     <= '0;
      s1_b     <= '0;
    end else begin
      s1_valid <= grant_any;
      s1_owner <= grant1;
      if (grant_any) begin
        rr_ptr <= grant0;
      end
      s1_func <= grant1 ? Req1_func_in : (grant0 ? Req0_func_in : '0);
      s1_a    <= grant1 ? Req1_a_in    : (grant0 ? Req0_a_in    : '0);
      s1_b    <= grant1 ? Req1_b_in    : (grant0 ? Req0_b_in    : '0);
    end
  end

  assign Alu_func_out = s1_func;
  assign Alu_a_out    = s1_a;
  assign Alu_b_out    = s1_b;

  // result payload only updates with a valid op so it holds between responses
  always_ff @(posedge Clk_in or negedge Reset_n_in) begin
    if (!Reset_n_in) begin
      s2_valid        <= 1'b0;
      s2_owner        <= 1'b0;
      Resp_result_out <= '0;
      Resp_branch_out <= 1'b0;
      Resp_jump_out   <= 1'b0;
      Resp_err_out    <= 1'b0;
    end else begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_owner        <= s1_owner;
        Resp_err_out    <= ~s1_legal;
        Resp_result_out <= s1_legal ? Alu_o_in : '0;
        Resp_branch_out <= s1_legal & Alu_branch_in;
        Resp_jump_out   <= s1_legal & Alu_jump_in;
      end
    end
  end

  assign Resp0_valid_out = s2_valid & ~s2_owner;
  assign Resp1_valid_out = s2_valid & s2_owner;
  assign Busy_out        = s1_valid | s2_valid;

endmodule
